alu_unit: RTL

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_unit.sv
// 16-bit add/sub ALU built on a nibble-serial 4-bit adder (LSB nibble first),
// with a level start/done handshake and registered result and flags.
module alu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_start,
  input  logic        alu_op,
  input  logic        immediate,
  input  logic [15:0] rs1_data,
  input  logic [15:0] rs2_data,
  input  logic [15:0] sgnext_imm,
  output logic [15:0] alu_result,
  output logic        alu_done,
  output logic        alu_busy,
  output logic        alu_carry,
  output logic        alu_overflow,
  output logic        alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [4:0] nib_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci);
    nib_add = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [11:0] sum_q, sum_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        cin_q, cin_d;
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [4:0]  nib_s;
  logic [15:0] res_s;
  logic [15:0] bsel_s;

  assign nib_s  = nib_add(a_q[3:0], b_q[3:0], cin_q);
  assign res_s  = {nib_s[3:0], sum_q};
  assign bsel_s = immediate ? sgnext_imm : rs2_data;

  // Next-state, operand shifting and result/flag capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    cin_d    = cin_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (alu_start) begin
          a_d     = rs1_data;
          b_d     = alu_op ? ~bsel_s : bsel_s;
          cin_d   = alu_op;
          cnt_d   = 2'd0;
          sum_d   = 12'h000;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d   = {4'h0, a_q[15:4]};
        b_d   = {4'h0, b_q[15:4]};
        sum_d = {nib_s[3:0], sum_q[11:4]};
        cin_d = nib_s[4];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // On the last nibble a_q[3]/b_q[3] are the sign bits of A and B'.
          result_d = res_s;
          carry_d  = nib_s[4];
          ovf_d    = (a_q[3] == b_q[3]) && (nib_s[3] != a_q[3]);
          zero_d   = (res_s == 16'h0000);
          state_d  = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (!alu_start) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      sum_q    <= 12'h000;
      cnt_q    <= 2'd0;
      cin_q    <= 1'b0;
      result_q <= 16'h0000;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign alu_result   = result_q;
  assign alu_done     = done_q;
  assign alu_busy     = busy_q;
  assign alu_carry    = carry_q;
  assign alu_overflow = ovf_q;
  assign alu_zero     = zero_q;

endmodule
